// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with illegal-opcode and memory-timeout faults.
// Define PERF_CNT_EN to add the cycle_count / instret_count performance counters.
module multicycle_ctrl_fsm #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode,
    input  logic            mem_ready,
    input  logic            branch_taken,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic [2:0]      imm_sel,
    output logic            alu_src_a,
    output logic            alu_src_b,
    output logic            mem_req,
    output logic            mem_we,
    output logic            mem_is_fetch,
    output logic            reg_write,
    output logic [1:0]      wb_sel,
    output logic            retire,
    output logic            fault,
    output logic [1:0]      fault_cause
`ifdef PERF_CNT_EN
   ,output logic [XLEN-1:0] cycle_count,
    output logic [XLEN-1:0] instret_count
`endif
);

    // Wait counter only has to reach MEM_TIMEOUT; never wider than the datapath.
    localparam int CNT_RAW = $clog2(MEM_TIMEOUT + 2);
    localparam int CNT_W   = (CNT_RAW < XLEN) ? CNT_RAW : XLEN;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd7;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
    } state_t;

    state_t           r_state;
    logic [6:0]       r_opc;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_wait;

    logic w_is_branch, w_is_load, w_is_store, w_is_jal, w_is_jalr;
    logic w_is_auipc, w_is_op, w_timeout;

    function automatic logic f_legal(input logic [6:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: f_legal = 1'b1;
            default:                                f_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] f_imm_sel(input logic [6:0] op);
        case (op)
            OPC_OPIMM, OPC_LOAD, OPC_JALR: f_imm_sel = IMM_I;
            OPC_STORE:                     f_imm_sel = IMM_S;
            OPC_BRANCH:                    f_imm_sel = IMM_B;
            OPC_LUI, OPC_AUIPC:            f_imm_sel = IMM_U;
            OPC_JAL:                       f_imm_sel = IMM_J;
            default:                       f_imm_sel = IMM_NONE;
        endcase
    endfunction

    assign w_is_branch = (r_opc == OPC_BRANCH);
    assign w_is_load   = (r_opc == OPC_LOAD);
    assign w_is_store  = (r_opc == OPC_STORE);
    assign w_is_jal    = (r_opc == OPC_JAL);
    assign w_is_jalr   = (r_opc == OPC_JALR);
    assign w_is_auipc  = (r_opc == OPC_AUIPC);
    assign w_is_op     = (r_opc == OPC_OP);

    // A ready arriving in the same cycle the limit is reached still completes the transaction.
    assign w_timeout = (MEM_TIMEOUT > 0) && (r_wait == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cause <= 2'd0;
            r_wait  <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_cause <= CAUSE_TIMEOUT;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (f_legal(opcode)) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_FAULT;
                        r_cause <= CAUSE_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    if (w_is_branch) begin
                        r_state <= S_FETCH;
                        r_wait  <= '0;
                    end else if (w_is_load || w_is_store) begin
                        r_state <= S_MEM;
                        r_wait  <= '0;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_is_load) begin
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FETCH;
                            r_wait  <= '0;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_cause <= CAUSE_TIMEOUT;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                end
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Opcode is captured once, so IR changes after DECODE do not disturb the instruction.
    always_ff @(posedge clk) begin
        if (r_state == S_DECODE) r_opc <= opcode;
    end

    always_comb begin
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        imm_sel      = IMM_NONE;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        retire       = 1'b0;
        fault        = 1'b0;
        fault_cause  = 2'd0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_req      = 1'b1;
                    mem_is_fetch = 1'b1;
                    ir_write     = mem_ready;
                end
                S_EXEC: begin
                    imm_sel = f_imm_sel(r_opc);
                    if (w_is_branch) begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? 2'd1 : 2'd0;
                        retire   = 1'b1;
                    end else if (w_is_load || w_is_store) begin
                        alu_src_b = 1'b1;
                    end else begin
                        alu_src_a = w_is_auipc || w_is_jal;
                        alu_src_b = !w_is_op;
                    end
                end
                S_MEM: begin
                    imm_sel = f_imm_sel(r_opc);
                    mem_req = 1'b1;
                    mem_we  = w_is_store;
                    if (mem_ready && w_is_store) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                S_WB: begin
                    imm_sel   = f_imm_sel(r_opc);
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    wb_sel    = w_is_load ? 2'd1 : ((w_is_jal || w_is_jalr) ? 2'd2 : 2'd0);
                    pc_src    = w_is_jal ? 2'd1 : (w_is_jalr ? 2'd2 : 2'd0);
                end
                S_FAULT: begin
                    fault       = 1'b1;
                    fault_cause = r_cause;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (r_state != S_FAULT) cycle_count <= cycle_count + XLEN'(1);
            if (retire) instret_count <= instret_count + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: vector table, hand-written corner sequences and random instructions.
module tb_multicycle_ctrl_fsm;

    localparam int TMO = 4;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OPR    = 7'b0110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready, branch_taken;
    logic       ir_write, pc_write, alu_src_a, alu_src_b, mem_req, mem_we, mem_is_fetch;
    logic       reg_write, retire, fault;
    logic [1:0] pc_src, wb_sel, fault_cause;
    logic [2:0] imm_sel;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_count, instret_count;
`endif

    multicycle_ctrl_fsm #(.XLEN(32), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .imm_sel(imm_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mem_req(mem_req), .mem_we(mem_we),
        .mem_is_fetch(mem_is_fetch), .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire),
        .fault(fault), .fault_cause(fault_cause)
`ifdef PERF_CNT_EN
       ,.cycle_count(cycle_count), .instret_count(instret_count)
`endif
    );

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [2:0] imm_sel;
        logic       alu_a;
        logic       alu_b;
        logic       mem_req;
        logic       mem_we;
        logic       fetch;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       retire;
        logic       fault;
        logic [1:0] cause;
    } outs_t;

    outs_t act;
    assign act = {ir_write, pc_write, pc_src, imm_sel, alu_src_a, alu_src_b, mem_req, mem_we,
                  mem_is_fetch, reg_write, wb_sel, retire, fault, fault_cause};

    logic [6:0] legal_ops [9] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OPR};

    int  checks = 0;
    int  errors = 0;
    int  retire_at;
    int  cyc_idx;
    bit  faulted;
    bit  dut_fault_seen;
`ifdef PERF_CNT_EN
    int unsigned m_cyc, m_inst;
`endif

    function automatic outs_t quiet();
        outs_t o;
        o = '0;
        o.imm_sel = 3'd7;
        return o;
    endfunction

    function automatic logic [2:0] fmt(input logic [6:0] op);
        case (op)
            OPIMM, LOAD, JALR: return 3'd0;
            STORE:             return 3'd1;
            BRANCH:            return 3'd2;
            LUI, AUIPC:        return 3'd3;
            JAL:               return 3'd4;
            default:           return 3'd7;
        endcase
    endfunction

    function automatic bit legal(input logic [6:0] op);
        foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs, compare at the falling edge, advance the reference counters.
    task automatic check_cycle(input outs_t exp, input logic rdy, input logic bt,
                               input logic [6:0] op, input string tag);
        opcode = op;
        mem_ready = rdy;
        branch_taken = bt;
        @(negedge clk);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %h required %h (t=%0t)", tag, act, exp, $time);
        end
        if (act.retire === 1'b1 && retire_at == 0) retire_at = cyc_idx;
        if (act.fault === 1'b1) dut_fault_seen = 1'b1;
`ifdef PERF_CNT_EN
        checks += 2;
        if (cycle_count !== m_cyc) begin
            errors++;
            $display("FAIL %s cycle_count: got %0d required %0d", tag, cycle_count, m_cyc);
        end
        if (instret_count !== m_inst) begin
            errors++;
            $display("FAIL %s instret_count: got %0d required %0d", tag, instret_count, m_inst);
        end
`endif
        @(posedge clk);
`ifdef PERF_CNT_EN
        if (!exp.fault) m_cyc++;
        if (exp.retire) m_inst++;
`endif
        cyc_idx++;
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        mem_ready = 1'($urandom);
        opcode = 7'($urandom);
        branch_taken = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (act !== quiet()) begin
                errors++;
                $display("FAIL reset_outputs: got %h required %h", act, quiet());
            end
`ifdef PERF_CNT_EN
            if (i > 0) begin
                checks++;
                if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_counters: got %0d/%0d required 0/0", cycle_count, instret_count);
                end
            end
`endif
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
`ifdef PERF_CNT_EN
        m_cyc = 0;
        m_inst = 0;
`endif
    endtask

    task automatic fault_hold(input logic [1:0] cause, input int n);
        outs_t e;
        e = quiet();
        e.fault = 1'b1;
        e.cause = cause;
        for (int i = 0; i < n; i++) check_cycle(e, 1'($urandom), 1'($urandom), 7'($urandom), "fault_hold");
    endtask

    // Expected behaviour of one instruction, phase by phase: fw/mw are the ready-low cycles per transaction.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit bt);
        outs_t e;
        bit    r;
        retire_at = 0;
        cyc_idx = 1;
        faulted = 1'b0;
        dut_fault_seen = 1'b0;
        for (int i = 0; i <= fw; i++) begin
            r = (i == fw);
            e = quiet();
            e.mem_req = 1'b1;
            e.fetch = 1'b1;
            e.ir_write = r;
            check_cycle(e, r, 1'($urandom), 7'($urandom), "fetch");
            if (!r && i == TMO) begin
                faulted = 1'b1;
                fault_hold(2'd2, 3);
                return;
            end
        end
        check_cycle(quiet(), 1'($urandom), 1'($urandom), op, "decode");
        if (!legal(op)) begin
            faulted = 1'b1;
            fault_hold(2'd1, 3);
            return;
        end
        e = quiet();
        e.imm_sel = fmt(op);
        if (op == BRANCH) begin
            e.pc_write = 1'b1;
            e.pc_src = bt ? 2'd1 : 2'd0;
            e.retire = 1'b1;
        end else if (op == LOAD || op == STORE) begin
            e.alu_b = 1'b1;
        end else begin
            e.alu_a = (op == AUIPC || op == JAL);
            e.alu_b = (op != OPR);
        end
        check_cycle(e, 1'($urandom), bt, 7'($urandom), "exec");
        if (op == BRANCH) return;
        if (op == LOAD || op == STORE) begin
            for (int j = 0; j <= mw; j++) begin
                r = (j == mw);
                e = quiet();
                e.imm_sel = fmt(op);
                e.mem_req = 1'b1;
                e.mem_we = (op == STORE);
                if (r && op == STORE) begin
                    e.pc_write = 1'b1;
                    e.retire = 1'b1;
                end
                check_cycle(e, r, 1'($urandom), 7'($urandom), "mem");
                if (!r && j == TMO) begin
                    faulted = 1'b1;
                    fault_hold(2'd2, 3);
                    return;
                end
            end
            if (op == STORE) return;
        end
        e = quiet();
        e.imm_sel = fmt(op);
        e.reg_write = 1'b1;
        e.pc_write = 1'b1;
        e.retire = 1'b1;
        e.wb_sel = (op == LOAD) ? 2'd1 : ((op == JAL || op == JALR) ? 2'd2 : 2'd0);
        e.pc_src = (op == JAL) ? 2'd1 : ((op == JALR) ? 2'd2 : 2'd0);
        check_cycle(e, 1'($urandom), 1'($urandom), 7'($urandom), "wb");
    endtask

    typedef struct {
        logic [6:0] op;
        int         fw;
        int         mw;
        bit         bt;
        int         exp_ret;
        bit         exp_fault;
        string      name;
    } vec_t;

    initial begin
        vec_t  tbl [15];
        outs_t e;
        int    fw, mw;
        logic [6:0] op;

        tbl[0]  = '{OPIMM,   0, 0, 1'b0, 4, 1'b0, "addi"};
        tbl[1]  = '{LOAD,    0, 3, 1'b0, 8, 1'b0, "lw_wait3"};
        tbl[2]  = '{BRANCH,  0, 0, 1'b1, 3, 1'b0, "beq_taken"};
        tbl[3]  = '{BRANCH,  0, 0, 1'b0, 3, 1'b0, "beq_not"};
        tbl[4]  = '{STORE,   0, 0, 1'b0, 4, 1'b0, "sw"};
        tbl[5]  = '{LOAD,    0, 0, 1'b0, 5, 1'b0, "lw"};
        tbl[6]  = '{JAL,     0, 0, 1'b0, 4, 1'b0, "jal"};
        tbl[7]  = '{JALR,    0, 0, 1'b0, 4, 1'b0, "jalr"};
        tbl[8]  = '{LUI,     0, 0, 1'b0, 4, 1'b0, "lui"};
        tbl[9]  = '{AUIPC,   2, 0, 1'b0, 6, 1'b0, "auipc_fw2"};
        tbl[10] = '{OPR,     1, 0, 1'b0, 5, 1'b0, "add_fw1"};
        tbl[11] = '{7'h7f,   0, 0, 1'b0, 0, 1'b1, "illegal"};
        tbl[12] = '{OPIMM,   5, 0, 1'b0, 0, 1'b1, "fetch_timeout"};
        tbl[13] = '{OPIMM,   4, 0, 1'b0, 8, 1'b0, "fetch_ready_at_limit"};
        tbl[14] = '{LOAD,    0, 5, 1'b0, 0, 1'b1, "mem_timeout"};

        rst = 1'b1;
        opcode = 7'd0;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        do_reset(2);

        for (int t = 0; t < 15; t++) begin
            run_instr(tbl[t].op, tbl[t].fw, tbl[t].mw, tbl[t].bt);
            checks++;
            if (retire_at != tbl[t].exp_ret || dut_fault_seen != tbl[t].exp_fault) begin
                errors++;
                $display("FAIL %s: retire cycle %0d fault %0b, required %0d fault %0b",
                         tbl[t].name, retire_at, dut_fault_seen, tbl[t].exp_ret, tbl[t].exp_fault);
            end
            if (faulted) do_reset(1);
        end

        // Reset in the middle of a store's MEM wait: aborted, no retire, back to a clean fetch.
        retire_at = 0;
        cyc_idx = 1;
        e = quiet(); e.mem_req = 1'b1; e.fetch = 1'b1; e.ir_write = 1'b1;
        check_cycle(e, 1'b1, 1'b0, 7'($urandom), "rst_sw_fetch");
        check_cycle(quiet(), 1'b0, 1'b0, STORE, "rst_sw_decode");
        e = quiet(); e.imm_sel = 3'd1; e.alu_b = 1'b1;
        check_cycle(e, 1'b0, 1'b0, 7'($urandom), "rst_sw_exec");
        e = quiet(); e.imm_sel = 3'd1; e.mem_req = 1'b1; e.mem_we = 1'b1;
        check_cycle(e, 1'b0, 1'b0, 7'($urandom), "rst_sw_mem0");
        check_cycle(e, 1'b0, 1'b0, 7'($urandom), "rst_sw_mem1");
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (act !== quiet()) begin
            errors++;
            $display("FAIL rst_mid_mem: got %h required %h", act, quiet());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef PERF_CNT_EN
        m_cyc = 0;
        m_inst = 0;
`endif
        e = quiet(); e.mem_req = 1'b1; e.fetch = 1'b1;
        check_cycle(e, 1'b0, 1'b0, 7'($urandom), "after_rst_fetch");
        checks++;
        if (retire_at != 0) begin
            errors++;
            $display("FAIL rst_mid_retire: retire seen at cycle %0d required none", retire_at);
        end
        e.ir_write = 1'b1;
        check_cycle(e, 1'b1, 1'b0, 7'($urandom), "after_rst_fetch_done");
        check_cycle(quiet(), 1'b0, 1'b0, OPR, "after_rst_decode");
        e = quiet();
        check_cycle(e, 1'b0, 1'b0, 7'($urandom), "after_rst_exec");
        e = quiet(); e.reg_write = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1;
        check_cycle(e, 1'b0, 1'b0, 7'($urandom), "after_rst_wb");

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            else op = legal_ops[$urandom_range(0, 8)];
            fw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 5));
            mw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 5));
            run_instr(op, fw, mw, 1'($urandom));
            if (faulted) do_reset(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
